// File: rtl/carregador_programa_pkg.sv
// ---------------------------------------------------------------------------
// carregador_programa_pkg
// Shared definitions for the UART program loader:
//   estado_t     - loader FSM states
//   rx_estado_t  - UART receiver states
//   START_BIT / STOP_BIT / DATA_BITS - 8N1 frame constants
// Optional feature macro used by the loader: CARREGADOR_CHECKSUM_EN
// ---------------------------------------------------------------------------
package carregador_programa_pkg;

   typedef enum logic [2:0] {
      OCIOSO,
      CONT_HI,
      CONT_LO,
      DADOS,
      ESCRITA,
      PRONTO,
      ERRO
   } estado_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_estado_t;

   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;
   localparam int   DATA_BITS = 8;

endpackage

// File: rtl/carregador_programa_uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver, LSB first, idle-high line.
// Ports:
//   clk       - system clock, rising edge
//   resetN    - asynchronous active-low reset
//   rx        - serial line, asynchronous to clk
//   byteValid - one-cycle pulse, byteData holds a correctly framed byte
//   byteData  - received byte
//   frameErr  - one-cycle pulse when the stop bit was sampled low
// ---------------------------------------------------------------------------
module uart_rx
   import carregador_programa_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       resetN,
   input  logic       rx,
   output logic       byteValid,
   output logic [7:0] byteData,
   output logic       frameErr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic       rxMeta, rxSync, rxPrev;
   rx_estado_t rxStateReg, rxStateNext;
   logic [CW-1:0] cntReg, cntNext;
   logic [2:0] bitIdxReg, bitIdxNext;
   logic [7:0] shiftReg, shiftNext;

   // Two-flop synchronizer plus one delay stage for edge detection.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
         rxPrev <= 1'b1;
      end else begin
         rxMeta <= rx;
         rxSync <= rxMeta;
         rxPrev <= rxSync;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         rxStateReg <= RX_IDLE;
         cntReg     <= '0;
         bitIdxReg  <= '0;
         shiftReg   <= '0;
      end else begin
         rxStateReg <= rxStateNext;
         cntReg     <= cntNext;
         bitIdxReg  <= bitIdxNext;
         shiftReg   <= shiftNext;
      end
   end

   always_comb begin
      rxStateNext = rxStateReg;
      cntNext     = cntReg;
      bitIdxNext  = bitIdxReg;
      shiftNext   = shiftReg;
      byteValid   = 1'b0;
      frameErr    = 1'b0;
      unique case (rxStateReg)
         RX_IDLE: begin
            // A true falling edge is required, so a line held low after a
            // framing error does not retrigger the receiver.
            if (rxPrev && (rxSync == START_BIT)) begin
               rxStateNext = RX_START;
               cntNext     = '0;
            end
         end
         RX_START: begin
            if (cntReg == CNT_HALF) begin
               cntNext    = '0;
               bitIdxNext = '0;
               rxStateNext = (rxSync == START_BIT) ? RX_DATA : RX_IDLE;
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         RX_DATA: begin
            if (cntReg == CNT_LAST) begin
               cntNext   = '0;
               shiftNext = {rxSync, shiftReg[7:1]};
               if (bitIdxReg == 3'(DATA_BITS - 1)) rxStateNext = RX_STOP;
               else                                 bitIdxNext = bitIdxReg + 1'b1;
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         RX_STOP: begin
            if (cntReg == CNT_LAST) begin
               cntNext     = '0;
               rxStateNext = RX_IDLE;
               if (rxSync == STOP_BIT) byteValid = 1'b1;
               else                    frameErr  = 1'b1;
            end else begin
               cntNext = cntReg + 1'b1;
            end
         end
         default: rxStateNext = RX_IDLE;
      endcase
   end

   assign byteData = shiftReg;

endmodule

// File: rtl/carregador_programa.sv
// ---------------------------------------------------------------------------
// carregador_programa
// Loads a program received over UART into instruction memory.
// Stream: count hi, count lo (N words), then N words MSB first
// (optionally followed by an XOR checksum byte when the macro
// CARREGADOR_CHECKSUM_EN is defined).
// Ports:
//   CLK, Reset (async, active-low), RX (serial), Start (load request pulse)
//   IMemEndereco/IMemDado/IMemWrite - instruction memory write port
//   HLTCarga    - processor halt while loading or in error
//   CargaPronta - last load completed successfully
//   NumPalavras - words written by the current/last load
//   Erro        - sticky error, cleared by Start
// ---------------------------------------------------------------------------
module carregador_programa
   import carregador_programa_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 10
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              RX,
   input  logic              Start,
   output logic [ADDR_W-1:0] IMemEndereco,
   output logic [31:0]       IMemDado,
   output logic              IMemWrite,
   output logic              HLTCarga,
   output logic              CargaPronta,
   output logic [ADDR_W:0]   NumPalavras,
   output logic              Erro
);

   localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

   logic        byteValid, frameErr;
   logic [7:0]  byteData;
   estado_t     stateReg, stateNext;
   logic [15:0] countReg;
   logic [1:0]  byteIdxReg;
   logic [31:0] wordReg;
   logic [ADDR_W:0] numPalavrasReg;
   logic [15:0] countRx;
   logic        lastWord;
   logic        awaitChk;
   logic        idleLike;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) uRx (
      .clk       (CLK),
      .resetN    (Reset),
      .rx        (RX),
      .byteValid (byteValid),
      .byteData  (byteData),
      .frameErr  (frameErr)
   );

   assign countRx  = {countReg[15:8], byteData};
   assign lastWord = (16'(numPalavrasReg) + 16'd1) == countReg;
   assign idleLike = (stateReg == OCIOSO) || (stateReg == PRONTO) || (stateReg == ERRO);

`ifdef CARREGADOR_CHECKSUM_EN
   logic [7:0] xorReg;
   // All words written: the next byte in DADOS is the checksum.
   assign awaitChk = (16'(numPalavrasReg) == countReg);
`else
   assign awaitChk = 1'b0;
`endif

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         stateReg       <= OCIOSO;
         countReg       <= '0;
         byteIdxReg     <= '0;
         wordReg        <= '0;
         numPalavrasReg <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
         xorReg         <= '0;
`endif
      end else begin
         stateReg <= stateNext;
         if (idleLike && Start) begin
            countReg       <= '0;
            byteIdxReg     <= '0;
            numPalavrasReg <= '0;
`ifdef CARREGADOR_CHECKSUM_EN
            xorReg         <= '0;
`endif
         end
         if (stateReg == CONT_HI && byteValid) countReg[15:8] <= byteData;
         if (stateReg == CONT_LO && byteValid) countReg[7:0]  <= byteData;
         if (stateReg == DADOS && byteValid && !awaitChk) begin
            wordReg    <= {wordReg[23:0], byteData};
            byteIdxReg <= byteIdxReg + 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
            xorReg     <= xorReg ^ byteData;
`endif
         end
         if (stateReg == ESCRITA) numPalavrasReg <= numPalavrasReg + 1'b1;
      end
   end

   always_comb begin
      stateNext = stateReg;
      unique case (stateReg)
         OCIOSO, PRONTO, ERRO: begin
            if (Start) stateNext = CONT_HI;
         end
         // Framing errors only matter while a load is being received;
         // line noise while idle is ignored like any other idle byte.
         CONT_HI: begin
            if (frameErr)       stateNext = ERRO;
            else if (byteValid) stateNext = CONT_LO;
         end
         CONT_LO: begin
            if (frameErr) stateNext = ERRO;
            else if (byteValid) begin
               if ({1'b0, countRx} > MAX_WORDS) stateNext = ERRO;
`ifdef CARREGADOR_CHECKSUM_EN
               else                             stateNext = DADOS;
`else
               else if (countRx == 16'd0)       stateNext = PRONTO;
               else                             stateNext = DADOS;
`endif
            end
         end
         DADOS: begin
            if (frameErr) stateNext = ERRO;
            else if (byteValid) begin
`ifdef CARREGADOR_CHECKSUM_EN
               if (awaitChk)                 stateNext = (byteData == xorReg) ? PRONTO : ERRO;
               else if (byteIdxReg == 2'd3)  stateNext = ESCRITA;
`else
               if (byteIdxReg == 2'd3)       stateNext = ESCRITA;
`endif
            end
         end
         ESCRITA: begin
`ifdef CARREGADOR_CHECKSUM_EN
            stateNext = DADOS;
`else
            stateNext = lastWord ? PRONTO : DADOS;
`endif
         end
         default: stateNext = OCIOSO;
      endcase
   end

   assign IMemWrite    = (stateReg == ESCRITA);
   assign IMemDado     = wordReg;
   assign IMemEndereco = numPalavrasReg[ADDR_W-1:0];
   assign NumPalavras  = numPalavrasReg;
   assign CargaPronta  = (stateReg == PRONTO);
   assign Erro         = (stateReg == ERRO);
   assign HLTCarga     = (stateReg == CONT_HI) || (stateReg == CONT_LO) ||
                         (stateReg == DADOS)   || (stateReg == ESCRITA) ||
                         (stateReg == ERRO);

endmodule

// File: tb/tb_carregador_programa.sv
// ---------------------------------------------------------------------------
// tb_carregador_programa
// Scoreboard bench: each load's expected memory writes are computed from the
// byte stream and queued; a monitor pops and compares on every IMemWrite.
// ---------------------------------------------------------------------------
module tb_carregador_programa;

   localparam int CPB = 4;
   localparam int AW  = 4;

   typedef logic [7:0] byte_q_t[$];
   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   logic          CLK = 1'b0;
   logic          Reset = 1'b1;
   logic          RX = 1'b1;
   logic          Start = 1'b0;
   logic [AW-1:0] IMemEndereco;
   logic [31:0]   IMemDado;
   logic          IMemWrite;
   logic          HLTCarga;
   logic          CargaPronta;
   logic [AW:0]   NumPalavras;
   logic          Erro;

   int  errors = 0;
   int  checks = 0;
   wr_t expQ[$];

   carregador_programa #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .CLK          (CLK),
      .Reset        (Reset),
      .RX           (RX),
      .Start        (Start),
      .IMemEndereco (IMemEndereco),
      .IMemDado     (IMemDado),
      .IMemWrite    (IMemWrite),
      .HLTCarga     (HLTCarga),
      .CargaPronta  (CargaPronta),
      .NumPalavras  (NumPalavras),
      .Erro         (Erro)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the head of the scoreboard.
   initial begin
      wr_t e;
      forever begin
         @(negedge CLK);
         if (IMemWrite === 1'b1) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr=%0h data=%08h required no write", IMemEndereco, IMemDado);
            end else begin
               e = expQ.pop_front();
               chk("write_addr", 64'(IMemEndereco), 64'(e.addr));
               chk("write_data", 64'(IMemDado), 64'(e.data));
               $display("write addr=%0h data=%08h", IMemEndereco, IMemDado);
            end
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      RX = 1'b0;
      repeat (CPB) @(negedge CLK);
      for (int i = 0; i < 8; i++) begin
         RX = b[i];
         repeat (CPB) @(negedge CLK);
      end
      RX = stopBit;
      repeat (CPB) @(negedge CLK);
      RX = 1'b1;
   endtask

   task automatic sendStream(input byte_q_t q);
      for (int i = 0; i < q.size(); i++) begin
         sendByte(q[i], 1'b1);
         repeat (CPB) @(negedge CLK);
      end
   endtask

   task automatic startLoad();
      @(negedge CLK);
      Start = 1'b1;
      @(negedge CLK);
      Start = 1'b0;
      repeat (2) @(negedge CLK);
   endtask

   // Reference: interpret the stream by the protocol rules, queue the
   // writes it implies and run the load, then check the end state.
   task automatic runLoad(input byte_q_t q, input string tag);
      int n;
      logic expOk;
      int expNum;
      logic [7:0] x;
      n = {q[0], q[1]};
      x = 8'h00;
      if (n > (1 << AW)) begin
         expOk  = 1'b0;
         expNum = 0;
      end else begin
         for (int w = 0; w < n; w++) begin
            wr_t e;
            e.addr = AW'(w);
            e.data = {q[2+4*w], q[3+4*w], q[4+4*w], q[5+4*w]};
            x = x ^ q[2+4*w] ^ q[3+4*w] ^ q[4+4*w] ^ q[5+4*w];
            expQ.push_back(e);
         end
         expNum = n;
         expOk  = 1'b1;
`ifdef CARREGADOR_CHECKSUM_EN
         expOk = (q.size() > 2 + 4*n) && (q[2+4*n] == x);
`endif
      end
      startLoad();
      sendStream(q);
      repeat (2) @(negedge CLK);
      chk({tag, "_pronto"}, 64'(CargaPronta), 64'(expOk));
      chk({tag, "_erro"}, 64'(Erro), 64'(!expOk));
      chk({tag, "_hlt"}, 64'(HLTCarga), 64'(!expOk));
      chk({tag, "_num"}, 64'(NumPalavras), 64'(expNum));
      chk({tag, "_pending_writes"}, 64'(expQ.size()), 64'd0);
      $display("load %s: N=%0d bytes=%0d ok=%0d words=%0d", tag, n, q.size(), expOk, NumPalavras);
   endtask

   initial begin
      byte_q_t q;
      int k;
      logic seen;

      // Reset state
      #2 Reset = 1'b0;
      #1;
      chk("rst_write", 64'(IMemWrite), 64'd0);
      chk("rst_hlt", 64'(HLTCarga), 64'd0);
      chk("rst_pronto", 64'(CargaPronta), 64'd0);
      chk("rst_erro", 64'(Erro), 64'd0);
      chk("rst_addr", 64'(IMemEndereco), 64'd0);
      chk("rst_dado", 64'(IMemDado), 64'd0);
      chk("rst_num", 64'(NumPalavras), 64'd0);
      repeat (3) @(negedge CLK);
      Reset = 1'b1;
      repeat (3) @(negedge CLK);

      // Two-word program
      q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      runLoad(q, "two_words");
`ifdef CARREGADOR_CHECKSUM_EN
      q.push_back(8'h00);
      runLoad(q, "chk_good");
      q[q.size()-1] = 8'h01;
      runLoad(q, "chk_bad");
`endif

      // Empty program: CargaPronta within 2 cycles of the final stop bit
      startLoad();
`ifdef CARREGADOR_CHECKSUM_EN
      q = '{8'h00, 8'h00, 8'h00};
`else
      q = '{8'h00, 8'h00};
`endif
      for (int i = 0; i < q.size() - 1; i++) begin
         sendByte(q[i], 1'b1);
         repeat (CPB) @(negedge CLK);
      end
      sendByte(q[q.size()-1], 1'b1);
      seen = 1'b0;
      for (int c = 0; c < 2 && !seen; c++) begin
         @(negedge CLK);
         seen = CargaPronta;
      end
      chk("n0_pronto_latency", 64'(seen), 64'd1);
      chk("n0_num", 64'(NumPalavras), 64'd0);
      $display("load empty: pronto=%0d", seen);
      repeat (CPB) @(negedge CLK);

      // Oversize count, then Start clears the error
      q = '{8'h00, 8'h11};
      runLoad(q, "oversize");
      startLoad();
      chk("oversize_start_clears_erro", 64'(Erro), 64'd0);
      chk("oversize_start_hlt", 64'(HLTCarga), 64'd1);
      $display("start after error: erro=%0d", Erro);

      // Framing error in the middle of the first word: no writes afterwards
      q = '{8'h00, 8'h02, 8'h12, 8'h34};
      sendStream(q);
      sendByte(8'h56, 1'b0);
      repeat (CPB + 2) @(negedge CLK);
      chk("frame_erro", 64'(Erro), 64'd1);
      chk("frame_hlt", 64'(HLTCarga), 64'd1);
      chk("frame_pronto", 64'(CargaPronta), 64'd0);
      q = '{8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
      sendStream(q);
      chk("frame_num", 64'(NumPalavras), 64'd0);
      chk("frame_erro_sticky", 64'(Erro), 64'd1);
      $display("framing error: erro=%0d num=%0d", Erro, NumPalavras);

      // Reset after the count plus the first word: one write at 0 only
      startLoad();
      begin
         wr_t e;
         e.addr = '0;
         e.data = 32'h12345678;
         expQ.push_back(e);
      end
      q = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78};
      sendStream(q);
      chk("rstmid_one_write", 64'(expQ.size()), 64'd0);
      Reset = 1'b0;
      #1;
      chk("rstmid_hlt", 64'(HLTCarga), 64'd0);
      chk("rstmid_num", 64'(NumPalavras), 64'd0);
      chk("rstmid_dado", 64'(IMemDado), 64'd0);
      chk("rstmid_addr", 64'(IMemEndereco), 64'd0);
      chk("rstmid_flags", 64'({IMemWrite, CargaPronta, Erro}), 64'd0);
      @(negedge CLK);
      Reset = 1'b1;
      q = '{8'h9A, 8'hBC, 8'hDE, 8'hF0};
      sendStream(q);
      chk("rstmid_idle_num", 64'(NumPalavras), 64'd0);
      chk("rstmid_idle_hlt", 64'(HLTCarga), 64'd0);
      $display("reset mid-load: num=%0d hlt=%0d", NumPalavras, HLTCarga);

      // Randomized loads, including full memory and oversize counts
      for (int t = 0; t < 6; t++) begin
         logic [7:0] x;
         q = {};
         k = (t == 0) ? 16 : (t == 1) ? 17 : $urandom_range(0, 18);
         q.push_back(8'(k >> 8));
         q.push_back(8'(k));
         x = 8'h00;
         if (k <= (1 << AW)) begin
            for (int b = 0; b < 4 * k; b++) begin
               logic [7:0] r;
               r = 8'($urandom);
               x = x ^ r;
               q.push_back(r);
            end
`ifdef CARREGADOR_CHECKSUM_EN
            if ($urandom_range(0, 3) == 0) q.push_back(x ^ 8'h5A);
            else                            q.push_back(x);
`endif
         end
         runLoad(q, $sformatf("rand%0d", t));
      end

      repeat (4) @(negedge CLK);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
